resilient_stage_ctrl: RTL
=========================

Name: resilient_stage_ctrl

Overview:
Synchronous, parametrised controller for one timing-resilient pipeline stage with N_ERR error-detection lanes and a configurable error window.
- Captures a token from the left valid/ready channel and pulses sample to the error detectors after ERR_WIN cycles.
- On a late error, waits RECOV_CYC cycles, recaptures and re-checks, bounded by MAX_RETRY.
- Delivers the token to the right channel and keeps error statistics.
- Sits between a datapath latch bank with error detectors and the next stage.

Parameters:
DW, 16, data width
N_ERR, 4, number of error-detection lanes
ERR_WIN, 2, cycles from capture to error sample (>=1)
RECOV_CYC, 2, recovery wait cycles after a detected error (>=1)
MAX_RETRY, 3, maximum recaptures per token (>=1)
CNT_W, 16, error counter width

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
l_valid  in  1  left token valid; source holds l_valid/l_data until l_ready
l_data  in  DW  left data
l_ready  out  1  single-cycle accept pulse (token consumed)
r_valid  out  1  right token valid (registered)
r_data  out  DW  right data (registered)
r_ready  in  1  right consumer ready
err  in  N_ERR  per-lane error flags; meaningful only in sample cycle
mode  in  2  00 normal, 01 ignore errors, 10 forced safe, 11 = normal
cap_en  out  1  datapath latch capture strobe
sample  out  1  error-detector sample strobe
err_cnt  out  CNT_W  saturating count of detected errors
err_lane_last  out  N_ERR  err vector of the most recent hit
err_fatal  out  1  sticky: a token left with an unresolved error

Behaviour:
- Reset (async, any state): state=IDLE. All outputs and counters 0. data_reg=0.
- IDLE:
  - Start when l_valid && (!r_valid || r_ready). Go to CAP; retry=0.
  - Otherwise stay in IDLE.
- CAP (1 cycle): cap_en=1; data_reg<=l_data. Go to WIN; wcnt=ERR_WIN-1.
- WIN:
  - When wcnt!=0: decrement wcnt.
  - When wcnt==0: sample=1; hit=|err.
  - Mode 00/11:
    - hit and retry<MAX_RETRY: err_cnt++, err_lane_last<=err, retry++, go to REC; rcnt=RECOV_CYC-1.
    - hit and retry==MAX_RETRY: err_cnt++, err_lane_last<=err, err_fatal<=1, go to ACK.
    - no hit: go to ACK.
  - Mode 01: on hit, err_cnt++ and err_lane_last<=err; no recovery; always go to ACK.
  - Mode 10: first pass (retry==0) always goes to REC, counting/latching only on a real hit; retry++. Later passes behave as mode 00.
- REC: no strobes. Decrement rcnt; when rcnt==0, go to CAP (recapture the now-settled l_data).
- ACK (1 cycle): l_ready=1; r_data<=data_reg; r_valid<=1. Go to IDLE.
- r_valid clears on r_valid && r_ready, unless ACK sets it in the same cycle.
- The start condition guarantees the output register is empty by ACK; no overwrite is possible.
- Latency, error-free: start cycle t0, CAP t1, WIN t1+1..t1+ERR_WIN, ACK t2+ERR_WIN, r_valid high from t3+ERR_WIN.
- Each retry adds RECOV_CYC+1+ERR_WIN cycles.
- err outside the sample cycle is ignored. err_cnt saturates at all-ones.
- mode is sampled in WIN only; a change mid-token affects only later decisions.
- err_fatal clears only on rst.

Test Plan:
1. Defaults, l_valid with l_data=0xA5A5 at t0, no err -> cap_en t1, sample t3, l_ready t4, r_valid=1 with r_data=0xA5A5 at t5, err_cnt=0.
2. err=4'b0100 at t3, l_data changed to 0xA5A4 at t5 -> REC t4-t5, cap_en t6, sample t8, l_ready t9, r_data=0xA5A4, err_cnt=1, err_lane_last=0100, err_fatal=0.
3. err=4'b0001 in every sample cycle -> 3 recaptures, 4 samples, then ACK; err_cnt=4, err_fatal=1, r_valid=1.
4. r_ready=0 holding a token while a second l_valid arrives -> stays in IDLE, no cap_en; r_ready=1 at t20 -> start t20, cap_en t21, first token dropped t20.
5. mode=01 with err=1111 -> no REC, l_ready at t4, err_cnt=1. mode=10 with err=0 -> one REC pass, l_ready at t9, err_cnt=0.
6. rst asserted mid-REC -> r_valid, l_ready, cap_en, sample, err_cnt and err_fatal go to 0 immediately. After release, a new token completes with error-free timing.

Source files
------------

// File: rtl/resilient_stage_ctrl.sv
// Purpose : controller for one timing-resilient pipeline stage (capture, error sample, recover/retry, deliver).
// Latency : error-free token takes ERR_WIN+3 cycles from start to r_valid; each retry adds RECOV_CYC+1+ERR_WIN.
// Backpr. : a new token starts only when the output register is empty or draining (r_ready); l_ready is a 1-cycle accept pulse.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   l_valid, l_data, l_ready  left channel; l_ready pulses once when the token is consumed
//   r_valid, r_data, r_ready  right channel; r_valid/r_data registered
//   err, mode                 per-lane error flags (used only in the sample cycle), operating mode
//   cap_en, sample            datapath latch capture strobe, error-detector sample strobe
//   err_cnt, err_lane_last    saturating error count, err vector of the latest hit
//   err_fatal                 sticky flag: a token was delivered with an unresolved error
module resilient_stage_ctrl #(
  parameter int DW        = 16,
  parameter int N_ERR     = 4,
  parameter int ERR_WIN   = 2,
  parameter int RECOV_CYC = 2,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             l_valid,
  input  logic [DW-1:0]    l_data,
  output logic             l_ready,
  output logic             r_valid,
  output logic [DW-1:0]    r_data,
  input  logic             r_ready,
  input  logic [N_ERR-1:0] err,
  input  logic [1:0]       mode,
  output logic             cap_en,
  output logic             sample,
  output logic [CNT_W-1:0] err_cnt,
  output logic [N_ERR-1:0] err_lane_last,
  output logic             err_fatal
);

  // Counter widths: each counter only has to hold its reload value (PARAM-1).
  localparam int WCNT_W  = (ERR_WIN > 1)   ? $clog2(ERR_WIN)       : 1;
  localparam int RCNT_W  = (RECOV_CYC > 1) ? $clog2(RECOV_CYC)     : 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [1:0] MODE_IGNORE = 2'b01;
  localparam logic [1:0] MODE_SAFE   = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAP  = 3'd1,
    WIN  = 3'd2,
    REC  = 3'd3,
    ACK  = 3'd4
  } state_t;

  state_t             state;
  logic [WCNT_W-1:0]  wcnt;
  logic [RCNT_W-1:0]  rcnt;
  logic [RETRY_W-1:0] retry;
  logic [DW-1:0]      data_reg;

  // Decision made in the sample cycle (WIN with wcnt==0). mode and err are
  // only looked at here, so changes elsewhere have no effect.
  logic start;
  logic hit;
  logic retry_left;
  logic do_recover;
  logic do_fatal;

  always_comb begin
    start      = l_valid && (!r_valid || r_ready);
    hit        = |err;
    retry_left = (retry < RETRY_W'(MAX_RETRY));
    do_recover = 1'b0;
    do_fatal   = 1'b0;
    if (mode == MODE_IGNORE) begin
      do_recover = 1'b0;
    end else if ((mode == MODE_SAFE) && (retry == '0)) begin
      // Safe mode always spends one recovery pass on the first capture.
      do_recover = 1'b1;
    end else begin
      do_recover = hit && retry_left;
      do_fatal   = hit && !retry_left;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wcnt          <= '0;
      rcnt          <= '0;
      retry         <= '0;
      data_reg      <= '0;
      l_ready       <= 1'b0;
      r_valid       <= 1'b0;
      r_data        <= '0;
      cap_en        <= 1'b0;
      sample        <= 1'b0;
      err_cnt       <= '0;
      err_lane_last <= '0;
      err_fatal     <= 1'b0;
    end else begin
      // Strobes are registered: each is raised on the transition into the
      // cycle where it must be visible, and defaults low otherwise.
      cap_en  <= 1'b0;
      sample  <= 1'b0;
      l_ready <= 1'b0;

      // Right-channel drain; ACK below overrides in the same cycle.
      if (r_valid && r_ready) begin
        r_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= CAP;
            retry  <= '0;
            cap_en <= 1'b1;
          end
        end

        CAP: begin
          data_reg <= l_data;
          wcnt     <= WCNT_W'(ERR_WIN - 1);
          state    <= WIN;
          sample   <= (ERR_WIN == 1);
        end

        WIN: begin
          if (wcnt != '0) begin
            wcnt   <= wcnt - 1'b1;
            sample <= (wcnt == WCNT_W'(1));
          end else begin
            if (hit) begin
              if (err_cnt != {CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + CNT_W'(1);
              end
              err_lane_last <= err;
            end
            if (do_fatal) begin
              err_fatal <= 1'b1;
            end
            if (do_recover) begin
              retry <= retry + 1'b1;
              rcnt  <= RCNT_W'(RECOV_CYC - 1);
              state <= REC;
            end else begin
              l_ready <= 1'b1;
              state   <= ACK;
            end
          end
        end

        REC: begin
          if (rcnt != '0) begin
            rcnt <= rcnt - 1'b1;
          end else begin
            // Recapture whatever the source now presents; it has had
            // RECOV_CYC cycles to settle.
            cap_en <= 1'b1;
            state  <= CAP;
          end
        end

        ACK: begin
          // Start condition guaranteed the output register is free here.
          r_data  <= data_reg;
          r_valid <= 1'b1;
          state   <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
